// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - in-order {pc, instr} FIFO between fetch and decode, flushed on redirect.
// Optional zero-latency empty-queue bypass under INST_QUEUE_BYPASS_EN.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_instr,
  input  logic [WIDTH-1:0] in_pc,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push;
  logic               pop;
  logic               bypass;

  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !empty || bypass;
  assign pop       = !empty && out_ready && !flush;
  // A bypassed word that decode takes this cycle never enters storage.
  assign push      = in_valid && in_ready && !flush && !(bypass && out_ready);

  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    if (bypass) begin
      out_instr = in_instr;
      out_pc    = in_pc;
    end else if (!empty) begin
      {out_pc, out_instr} = mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed scoreboard bench for inst_queue.
// Honours INST_QUEUE_BYPASS_EN when the design is built with it.
module tb_inst_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_instr;
  logic [WIDTH-1:0] in_pc;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  int checks = 0;
  int failures = 0;
  logic [2*WIDTH-1:0] sb[$];
  int m_cnt = 0;
  logic [WIDTH-1:0] held_instr;
  logic [WIDTH-1:0] held_pc;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs against the model before the edge, then advance.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] ins, input logic [WIDTH-1:0] pc,
                       input logic ordy, input logic fl);
    logic byp;
    logic exp_valid;
    logic [2*WIDTH-1:0] exp_data;
    logic do_push;
    logic do_pop;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    byp = (m_cnt == 0) && iv && !fl;
`else
    byp = 1'b0;
`endif
    exp_valid = (m_cnt != 0) || byp;
    exp_data  = byp ? {pc, ins} : ((m_cnt != 0) ? sb[0] : '0);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_instr", 64'(out_instr), 64'(exp_data[WIDTH-1:0]));
    chk("out_pc",    64'(out_pc),    64'(exp_data[2*WIDTH-1:WIDTH]));
    chk("count",     64'(count),     64'(m_cnt));
    chk("full",      64'(full),      64'(m_cnt == DEPTH));
    chk("empty",     64'(empty),     64'(m_cnt == 0));
    chk("in_ready",  64'(in_ready),  64'(m_cnt != DEPTH));
    do_pop  = (m_cnt != 0) && ordy && !fl;
    do_push = iv && (m_cnt != DEPTH) && !fl && !(byp && ordy);
    if (fl) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      if (do_pop) begin
        void'(sb.pop_front());
        m_cnt--;
      end
      if (do_push) begin
        sb.push_back({pc, ins});
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_empty",     64'(empty),     64'd1);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, fifth push refused, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h2008_0001 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_full",  64'(full),  64'd1);
    cycle(1'b1, 32'h2008_0005, 32'h10, 1'b0, 1'b0);
    chk("fifth_ignored", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle();

    // Steady push+pop at count 2 across pointer wrap.
    cycle(1'b1, 32'h1000_0000, 32'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h1000_0001, 32'h104, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h1000_0002 + 32'(i), 32'h108 + 32'(4 * i), 1'b1, 1'b0);
    chk("wrap_count", 64'(count), 64'd2);

    // Flush at count 3 with push and pop in the same cycle.
    cycle(1'b1, 32'h1000_0010, 32'h200, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(count), 64'd3);
    cycle(1'b1, 32'hDEAD_0001, 32'h204, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("flushed_absent", 64'(out_instr == 32'hDEAD_0001), 64'd0);
      idle();
    end

    // Head stable under decode stall.
    cycle(1'b1, 32'h3000_0001, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h3000_0002, 32'h304, 1'b0, 1'b0);
    held_instr = out_instr;
    held_pc    = out_pc;
    for (int i = 0; i < 5; i++) begin
      chk("hold_instr", 64'(out_instr), 64'h3000_0001);
      chk("hold_pc",    64'(out_pc),    64'(held_pc));
      idle();
    end
    chk("hold_instr_end", 64'(out_instr), 64'(held_instr));

    // Asynchronous reset mid-operation (queue holds 2 entries).
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count),     64'd0);
    chk("arst_full",  64'(full),      64'd0);
    chk("arst_empty", 64'(empty),     64'd1);
    sb.delete();
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h8C09_0000, 32'h400, 1'b0, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_instr", 64'(out_instr), 64'h8C09_0000);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle();

    // Empty queue with simultaneous in_valid/out_ready: bypass or one-cycle latency.
    in_valid = 1'b1; in_instr = 32'h0109_5020; in_pc = 32'h500; out_ready = 1'b1; flush = 1'b0;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_instr", 64'(out_instr), 64'h0109_5020);
`else
    chk("nobyp_valid", 64'(out_valid), 64'd0);
`endif
    cycle(1'b1, 32'h0109_5020, 32'h500, 1'b1, 1'b0);
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("nobyp_count", 64'(count), 64'd1);
`endif
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction buffer between the fetcher (IF) and the decode path (splitter/ctrl, ID).
- Captures each fetched {pc, instruction} pair into a small circular FIFO and presents entries in order to decode over a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards all buffered entries on a branch/jump redirect (flush).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- WIDTH, 32, instruction and PC width in bits.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  fetcher presents a valid instruction.
- in_instr  input  WIDTH  fetched instruction word.
- in_pc  input  WIDTH  PC of in_instr (fetcher B_PC).
- in_ready  output  1  queue can accept a push this cycle.
- flush  input  1  redirect (taken branch/jump); discard all contents.
- out_valid  output  1  head entry valid for decode.
- out_instr  output  WIDTH  head instruction.
- out_pc  output  WIDTH  head PC.
- out_ready  input  1  decode consumes head this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst low, asynchronous) clears:
  - wr_ptr, rd_ptr and count to 0.
  - out_valid = 0, full = 0, empty = 1, in_ready = 1.
  - out_instr and out_pc drive 0.
  - Storage contents are don't-care.
- Storage is a DEPTH-entry array of {pc, instr}. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: occurs when in_valid && in_ready && !flush. Writes mem[wr_ptr] and increments wr_ptr.
- Pop: occurs when out_valid && out_ready && !flush. Increments rd_ptr.
- in_ready = !full. It depends on registered state only and has no combinational path from out_ready. A push is refused when full, even if a pop happens in the same cycle.
- Simultaneous push and pop (count between 1 and DEPTH-1): both pointers advance and count is unchanged.
- count increments on push-only, decrements on pop-only, and is otherwise held.
- Latency: an entry pushed at edge N is visible on out_* after edge N (out_valid high in cycle N+1). Minimum IF-to-ID latency is 1 cycle.
- out_valid = !empty.
- out_instr/out_pc = mem[rd_ptr] when out_valid, else 0. Value 0 is sll $0,$0,0, i.e. a NOP.
- Head is stable: while out_valid && !out_ready, out_instr/out_pc do not change.
- Flush is synchronous and has highest priority. At the edge where flush = 1:
  - count, wr_ptr and rd_ptr go to 0.
  - Any same-cycle push or pop is ignored.
  - out_valid is low the cycle after.
  - An in_valid presented during the flush cycle is dropped; the fetcher re-presents the redirect target.
- Empty with out_ready high: no pop, no state change.
- Full with in_valid high: no write, wr_ptr and count held, storage unmodified.
- Reset asserted mid-operation: state clears immediately, without waiting for clk. Operation resumes on the first rising edge after rst returns high.

Optional Feature:
- Macro INST_QUEUE_BYPASS_EN.
- Defined:
  - When empty && in_valid && !flush, out_valid = 1 and out_instr/out_pc = in_instr/in_pc combinationally.
  - If out_ready is also high, the word is consumed directly. No write occurs and count stays 0 (zero-cycle latency).
  - If out_ready is low, a normal push occurs.
  - full/in_ready behaviour is unchanged.
- Undefined: no in-to-out combinational path; minimum latency is 1 cycle as above.

Test Plan:
- Reset, then 4 pushes (pc 0x00,0x04,0x08,0x0C; instr 0x20080001..0x20080004) with out_ready = 0 -> count = 4, full = 1, in_ready = 0. A 5th push is ignored. Pops then return 0x20080001..4 in order, then empty = 1 and out_instr = 0.
- At count = 2, drive in_valid and out_ready together for 6 cycles with incrementing instrs -> count stays 2. Output order matches push order across pointer wrap-around (wr_ptr passes 3 -> 0 twice).
- At count = 3, assert flush with in_valid = 1 and out_ready = 1 -> next cycle count = 0, out_valid = 0, and the flushed-cycle instruction never appears on out_instr.
- Hold out_ready = 0 with count = 2 for 5 cycles -> out_instr/out_pc constant at the first entry, out_valid = 1.
- Push 2 entries, then pull rst low between clock edges -> out_valid, count and full fall immediately (before the next clk edge), empty = 1. After release, a push of 0x8C090000 appears one cycle later.
- With INST_QUEUE_BYPASS_EN: empty queue, in_valid = 1, in_instr = 0x01095020, out_ready = 1 -> same-cycle out_valid = 1, out_instr = 0x01095020, count stays 0. Without the macro, the same stimulus yields out_valid = 0 that cycle and count = 1 after the edge.
